// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter with one holding slot per functional unit.
// Define CDB_BTU_PRIORITY_EN to let a full BTU slot always win without moving rr_ptr.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 5
`endif
`ifndef FU_BTU
`define FU_BTU 3
`endif

module cdb_arbiter #(
    parameter int  FU_NUM  = 4,
    parameter int  BTU_IDX = `FU_BTU,
    localparam int SEL_W   = (FU_NUM > 1) ? $clog2(FU_NUM) : 1
) (
    input  logic                                  clock,
    input  logic                                  reset_n,
    input  logic                                  squash,
    input  logic [FU_NUM-1:0]                     fu_valid,
    input  logic [FU_NUM-1:0][`XLEN-1:0]          fu_value,
    input  logic [FU_NUM-1:0][`ROB_TAG_LEN-1:0]   fu_rob_tag,
    input  logic                                  btu_mispredict,
    input  logic [`XLEN-1:0]                      btu_pc,
    output logic [FU_NUM-1:0]                     fu_ready,
    output logic [FU_NUM-1:0][`XLEN-1:0]          cdb_values,
    output logic                                  cdb_select_flag,
    output logic [SEL_W-1:0]                      cdb_select_signal,
    output logic [`ROB_TAG_LEN-1:0]               cdb_rob_tag,
    output logic                                  cdb_mispredict,
    output logic [`XLEN-1:0]                      cdb_pc
);

    logic [FU_NUM-1:0]                    full_q, full_d;
    logic [FU_NUM-1:0][`XLEN-1:0]         value_q, value_d;
    logic [FU_NUM-1:0][`ROB_TAG_LEN-1:0]  tag_q, tag_d;
    logic                                 misp_q, misp_d;
    logic [`XLEN-1:0]                     pc_q, pc_d;
    logic [SEL_W-1:0]                     rr_ptr_q, rr_ptr_d;

    logic                                 gnt_any;
    logic [SEL_W-1:0]                     gnt_idx;
    logic [FU_NUM-1:0]                    gnt_oh;
    logic [FU_NUM-1:0]                    load;
    logic [SEL_W:0]                       scan;

    // Search upward from rr_ptr; explicit wrap keeps non-power-of-two FU_NUM correct.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        scan    = '0;
        for (int k = 0; k < FU_NUM; k++) begin
            scan = {1'b0, rr_ptr_q} + (SEL_W+1)'(k);
            if (scan >= (SEL_W+1)'(FU_NUM))
                scan = scan - (SEL_W+1)'(FU_NUM);
            if (!gnt_any && full_q[scan[SEL_W-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = scan[SEL_W-1:0];
            end
        end
`ifdef CDB_BTU_PRIORITY_EN
        if (full_q[BTU_IDX]) begin
            gnt_any = 1'b1;
            gnt_idx = SEL_W'(BTU_IDX);
        end
`endif
    end

    always_comb begin
        gnt_oh = '0;
        if (gnt_any)
            gnt_oh[gnt_idx] = 1'b1;
    end

    assign fu_ready = ~full_q | gnt_oh;
    assign load     = fu_valid & fu_ready & {FU_NUM{~squash}};

    always_comb begin
        full_d  = squash ? '0 : (load | (full_q & ~gnt_oh));
        value_d = value_q;
        tag_d   = tag_q;
        misp_d  = misp_q;
        pc_d    = pc_q;
        for (int i = 0; i < FU_NUM; i++) begin
            if (load[i]) begin
                value_d[i] = fu_value[i];
                tag_d[i]   = fu_rob_tag[i];
            end
        end
        if (load[BTU_IDX]) begin
            misp_d = btu_mispredict;
            pc_d   = btu_pc;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt_any && !squash)
            rr_ptr_d = (gnt_idx == SEL_W'(FU_NUM-1)) ? '0 : gnt_idx + SEL_W'(1);
`ifdef CDB_BTU_PRIORITY_EN
        // BTU grants bypass the rotation so the other FUs keep their turn order.
        if (gnt_any && gnt_idx == SEL_W'(BTU_IDX))
            rr_ptr_d = rr_ptr_q;
`endif
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            full_q   <= '0;
            value_q  <= '0;
            tag_q    <= '0;
            misp_q   <= 1'b0;
            pc_q     <= '0;
            rr_ptr_q <= '0;
        end else begin
            full_q   <= full_d;
            value_q  <= value_d;
            tag_q    <= tag_d;
            misp_q   <= misp_d;
            pc_q     <= pc_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        for (int i = 0; i < FU_NUM; i++)
            cdb_values[i] = full_q[i] ? value_q[i] : '0;
    end

    assign cdb_select_flag   = gnt_any;
    assign cdb_select_signal = gnt_idx;
    assign cdb_rob_tag       = gnt_any ? tag_q[gnt_idx] : '0;
    assign cdb_mispredict    = gnt_oh[BTU_IDX] & misp_q;
    assign cdb_pc            = gnt_oh[BTU_IDX] ? pc_q : '0;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: vector table, contention scoreboard, priority and reset sequences.
module tb_cdb_arbiter;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              squash;
    logic [3:0]        fu_valid;
    logic [3:0][31:0]  fu_value;
    logic [3:0][4:0]   fu_rob_tag;
    logic              btu_mispredict;
    logic [31:0]       btu_pc;
    logic [3:0]        fu_ready;
    logic [3:0][31:0]  cdb_values;
    logic              cdb_select_flag;
    logic [1:0]        cdb_select_signal;
    logic [4:0]        cdb_rob_tag;
    logic              cdb_mispredict;
    logic [31:0]       cdb_pc;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    cdb_arbiter #(.FU_NUM(4), .BTU_IDX(3)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .squash            (squash),
        .fu_valid          (fu_valid),
        .fu_value          (fu_value),
        .fu_rob_tag        (fu_rob_tag),
        .btu_mispredict    (btu_mispredict),
        .btu_pc            (btu_pc),
        .fu_ready          (fu_ready),
        .cdb_values        (cdb_values),
        .cdb_select_flag   (cdb_select_flag),
        .cdb_select_signal (cdb_select_signal),
        .cdb_rob_tag       (cdb_rob_tag),
        .cdb_mispredict    (cdb_mispredict),
        .cdb_pc            (cdb_pc)
    );

    typedef struct {
        logic [3:0]  valid;
        logic        sq;
        logic        misp;
        logic [31:0] pc;
        logic [4:0]  tag_base;
        logic [31:0] val_base;
        logic        e_flag;
        logic [1:0]  e_sel;
        logic [4:0]  e_tag;
        logic [3:0]  e_ready;
        logic        e_misp;
        logic [31:0] e_pc;
        logic [31:0] e_val;
    } vec_t;

    typedef struct {
        int          fu;
        logic [4:0]  tag;
        logic [31:0] val;
    } sb_t;

    vec_t vecs [8];
    sb_t  sb_q [$];
    int   cnt  [4];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string name);
        check({name, "_flag"},  128'(cdb_select_flag),   128'(1'b0));
        check({name, "_ready"}, 128'(fu_ready),          128'(4'hF));
        check({name, "_sel"},   128'(cdb_select_signal), 128'(2'd0));
        check({name, "_tag"},   128'(cdb_rob_tag),       128'(5'd0));
        check({name, "_vals"},  128'(cdb_values),        128'(0));
        check({name, "_misp"},  128'(cdb_mispredict),    128'(1'b0));
        check({name, "_pc"},    128'(cdb_pc),            128'(32'd0));
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        fu_valid       = 4'h0;
        squash         = 1'b0;
        btu_mispredict = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic drive_fu(input int i);
        fu_rob_tag[i] = 5'((i << 3) | (cnt[i] & 7));
        fu_value[i]   = 32'hF000_0000 | 32'(i << 16) | 32'(cnt[i]);
    endtask

    initial begin
        int   exp_c;
        int   hit;
        logic [3:0] acc;

        //          valid    sq    misp  pc          tb     val_base       flag  sel    tag     ready    misp  pc          val
        vecs[0] = '{4'b0100, 1'b0, 1'b0, 32'h0,      5'd3,  32'hDEAD_BEED, 1'b1, 2'd2, 5'd5,  4'b1111, 1'b0, 32'h0,      32'hDEAD_BEEF};
        vecs[1] = '{4'b0000, 1'b0, 1'b0, 32'h0,      5'd0,  32'h0,         1'b0, 2'd0, 5'd0,  4'b1111, 1'b0, 32'h0,      32'h0};
        vecs[2] = '{4'b1001, 1'b0, 1'b1, 32'h1000,   5'd8,  32'h1111_0000, 1'b1, 2'd3, 5'd11, 4'b1110, 1'b1, 32'h1000,   32'h1111_0003};
        vecs[3] = '{4'b0000, 1'b0, 1'b0, 32'h0,      5'd0,  32'h0,         1'b1, 2'd0, 5'd8,  4'b1111, 1'b0, 32'h0,      32'h1111_0000};
        vecs[4] = '{4'b0000, 1'b0, 1'b0, 32'h0,      5'd0,  32'h0,         1'b0, 2'd0, 5'd0,  4'b1111, 1'b0, 32'h0,      32'h0};
`ifdef CDB_BTU_PRIORITY_EN
        vecs[5] = '{4'b1010, 1'b0, 1'b0, 32'h0,      5'd16, 32'h2222_0000, 1'b1, 2'd3, 5'd19, 4'b1101, 1'b0, 32'h0,      32'h2222_0003};
`else
        vecs[5] = '{4'b1010, 1'b0, 1'b0, 32'h0,      5'd16, 32'h2222_0000, 1'b1, 2'd1, 5'd17, 4'b0111, 1'b0, 32'h0,      32'h2222_0001};
`endif
        vecs[6] = '{4'b0001, 1'b1, 1'b0, 32'h0,      5'd24, 32'h3333_0000, 1'b0, 2'd0, 5'd0,  4'b1111, 1'b0, 32'h0,      32'h0};
        vecs[7] = '{4'b0000, 1'b0, 1'b0, 32'h0,      5'd0,  32'h0,         1'b0, 2'd0, 5'd0,  4'b1111, 1'b0, 32'h0,      32'h0};

        // Reset held two cycles with every FU requesting: nothing may load.
        reset_n        = 1'b0;
        squash         = 1'b0;
        fu_valid       = 4'hF;
        btu_mispredict = 1'b1;
        btu_pc         = 32'h55AA_55AA;
        for (int i = 0; i < 4; i++) begin
            fu_value[i]   = 32'hA5A5_0000 + 32'(i);
            fu_rob_tag[i] = 5'(i + 1);
        end
        repeat (2) begin
            @(negedge clock);
            check_idle("reset");
        end
        reset_n = 1'b1;

        for (int v = 0; v < 8; v++) begin
            fu_valid       = vecs[v].valid;
            squash         = vecs[v].sq;
            btu_mispredict = vecs[v].misp;
            btu_pc         = vecs[v].pc;
            for (int i = 0; i < 4; i++) begin
                fu_rob_tag[i] = vecs[v].tag_base + 5'(i);
                fu_value[i]   = vecs[v].val_base + 32'(i);
            end
            @(negedge clock);
            check($sformatf("vec%0d_flag", v),  128'(cdb_select_flag), 128'(vecs[v].e_flag));
            check($sformatf("vec%0d_sel", v),   128'(cdb_select_signal), 128'(vecs[v].e_sel));
            check($sformatf("vec%0d_tag", v),   128'(cdb_rob_tag), 128'(vecs[v].e_tag));
            check($sformatf("vec%0d_ready", v), 128'(fu_ready), 128'(vecs[v].e_ready));
            check($sformatf("vec%0d_misp", v),  128'(cdb_mispredict), 128'(vecs[v].e_misp));
            check($sformatf("vec%0d_pc", v),    128'(cdb_pc), 128'(vecs[v].e_pc));
            if (vecs[v].e_flag)
                check($sformatf("vec%0d_val", v), 128'(cdb_values[vecs[v].e_sel]), 128'(vecs[v].e_val));
            else
                check($sformatf("vec%0d_vals", v), 128'(cdb_values), 128'(0));
        end
        squash = 1'b0;

        // Full contention from rr_ptr = 0 with per-FU result streams.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cnt[i] = 0;
            drive_fu(i);
        end
        fu_valid = 4'hF;
        for (int c = 0; c < 18; c++) begin
            acc = fu_valid & fu_ready;
            for (int i = 0; i < 4; i++)
                if (acc[i])
                    sb_q.push_back('{i, fu_rob_tag[i], fu_value[i]});
            @(posedge clock);
            #1;
            for (int i = 0; i < 4; i++)
                if (acc[i]) begin
                    cnt[i]++;
                    drive_fu(i);
                end
            if (c == 11)
                fu_valid = 4'h0;
            @(negedge clock);
`ifdef CDB_BTU_PRIORITY_EN
            exp_c = 3;
`else
            exp_c = c % 4;
`endif
            if (c <= 11) begin
                check($sformatf("cont%0d_sel", c),   128'(cdb_select_signal), 128'(exp_c));
                check($sformatf("cont%0d_ready", c), 128'(fu_ready), 128'(4'b0001 << exp_c));
            end
            if (cdb_select_flag) begin
                hit = -1;
                for (int k = 0; k < sb_q.size(); k++)
                    if (hit < 0 && sb_q[k].fu == int'(cdb_select_signal))
                        hit = k;
                check($sformatf("cont%0d_found", c), 128'(hit >= 0), 128'(1'b1));
                if (hit >= 0) begin
                    check($sformatf("cont%0d_tag", c), 128'(cdb_rob_tag), 128'(sb_q[hit].tag));
                    check($sformatf("cont%0d_val", c), 128'(cdb_values[cdb_select_signal]), 128'(sb_q[hit].val));
                    sb_q.delete(hit);
                end
            end
        end
        check("cont_leftover", 128'(sb_q.size()), 128'(0));
        check("cont_idle_flag", 128'(cdb_select_flag), 128'(1'b0));

        // BTU and slot 0 loaded together with rr_ptr = 0.
        do_reset();
        fu_valid       = 4'b1001;
        fu_rob_tag[0]  = 5'h0A;
        fu_value[0]    = 32'hAAAA_0000;
        fu_rob_tag[3]  = 5'h1B;
        fu_value[3]    = 32'hBBBB_0003;
        btu_mispredict = 1'b1;
        btu_pc         = 32'h2000;
        @(negedge clock);
        fu_valid       = 4'h0;
        btu_mispredict = 1'b0;
`ifdef CDB_BTU_PRIORITY_EN
        check("prio1_sel", 128'(cdb_select_signal), 128'(2'd3));
        check("prio1_tag", 128'(cdb_rob_tag), 128'(5'h1B));
        check("prio1_misp", 128'(cdb_mispredict), 128'(1'b1));
        check("prio1_pc", 128'(cdb_pc), 128'(32'h2000));
        @(negedge clock);
        check("prio2_sel", 128'(cdb_select_signal), 128'(2'd0));
        check("prio2_tag", 128'(cdb_rob_tag), 128'(5'h0A));
        check("prio2_misp", 128'(cdb_mispredict), 128'(1'b0));
        check("prio2_pc", 128'(cdb_pc), 128'(32'h0));
`else
        check("prio1_sel", 128'(cdb_select_signal), 128'(2'd0));
        check("prio1_tag", 128'(cdb_rob_tag), 128'(5'h0A));
        check("prio1_misp", 128'(cdb_mispredict), 128'(1'b0));
        check("prio1_pc", 128'(cdb_pc), 128'(32'h0));
        @(negedge clock);
        check("prio2_sel", 128'(cdb_select_signal), 128'(2'd3));
        check("prio2_tag", 128'(cdb_rob_tag), 128'(5'h1B));
        check("prio2_misp", 128'(cdb_mispredict), 128'(1'b1));
        check("prio2_pc", 128'(cdb_pc), 128'(32'h2000));
`endif
        @(negedge clock);
        check("prio3_flag", 128'(cdb_select_flag), 128'(1'b0));

        // Reset while slots hold stalled results.
        fu_valid = 4'hF;
        @(negedge clock);
        fu_valid = 4'h0;
        check("stall_loaded", 128'(cdb_select_flag), 128'(1'b1));
        reset_n = 1'b0;
        @(negedge clock);
        check_idle("midreset");
        reset_n = 1'b1;
        @(negedge clock);
        check("after_reset_flag", 128'(cdb_select_flag), 128'(1'b0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin scheduler and result buffer for the shared common data bus. Each functional unit (FU) hands its completed result, ROB tag and (BTU only) mispredict/target PC to a one-entry holding slot. Every cycle the block grants at most one full slot and drives the `common_data_bus` select inputs (`in_values`, `select_flag`, `select_signal`, `ROB_tag`, `mispredict`, `pc`). FUs whose slot cannot drain are back-pressured through a ready handshake.

## Interface
- `FU_NUM`, default 4: number of requesting FUs. Index equals the `FUNC_UNIT` encoding.
- `BTU_IDX`, default `FU_BTU`: slot index carrying branch results.
- `clock`, input, 1: single clock.
- `reset_n`, input, 1: synchronous, active-low reset.
- `squash`, input, 1: pipeline flush on mispredict recovery.
- `fu_valid`, input, [FU_NUM]: FU i presents a result this cycle.
- `fu_value`, input, [FU_NUM][`XLEN`]: result data per FU.
- `fu_rob_tag`, input, [FU_NUM][`ROB_TAG_LEN`]: ROB tag per FU.
- `btu_mispredict`, input, 1: BTU mispredict flag, qualified by `fu_valid[BTU_IDX]`.
- `btu_pc`, input, `XLEN`: BTU resolved target PC.
- `fu_ready`, output, [FU_NUM]: slot i accepts a result at this edge.
- `cdb_values`, output, [FU_NUM][`XLEN`]: slot data, wired to CDB `in_values`.
- `cdb_select_flag`, output, 1: a grant is valid this cycle.
- `cdb_select_signal`, output, `FUNC_UNIT`: granted slot index.
- `cdb_rob_tag`, output, `ROB_TAG_LEN`: tag of the granted slot.
- `cdb_mispredict`, output, 1: BTU slot mispredict flag.
- `cdb_pc`, output, `XLEN`: BTU slot PC.

## Operation
- **Per-slot state:** `full`, `value`, `rob_tag`. The BTU slot also holds `mispredict` and `pc`. The arbiter holds one `rr_ptr` (`$clog2(FU_NUM)` bits).
- **Grant (combinational):** the grant goes to the first full slot searching from `rr_ptr` upward, wrapping modulo FU_NUM. This is correct for non-power-of-two FU_NUM.
- `cdb_select_flag` = any slot full. `cdb_select_signal` and `cdb_rob_tag` come from the granted slot.
- When no slot is full, `cdb_select_signal`, `cdb_rob_tag`, `cdb_mispredict` and `cdb_pc` are 0.
- `cdb_values[i]` always shows slot i's stored value. An empty slot shows 0.
- `fu_ready[i] = !full[i] || grant[i]`. A granted slot may refill at the same edge.
- **Accept:** `fu_valid[i] && fu_ready[i]` loads slot i at the edge and sets `full`.
- **Drain:** a granted slot with no simultaneous accept clears `full`. Its data register holds its value but is masked to 0 on `cdb_values`.
- **Pointer update:** when `cdb_select_flag` is 1, `rr_ptr <= (granted index + 1) mod FU_NUM`. Otherwise `rr_ptr` holds.
- **Squash:** all `full` bits clear at the edge, and any same-cycle accepts are discarded. The grant asserted in the squash cycle is still presented on the bus, because the ROB filters it. `rr_ptr` holds.
- `fu_valid[i]` with `fu_ready[i] = 0` is a stall. The FU must hold its data stable, and the arbiter never drops or duplicates a result.

## Timing
- **Reset** (`reset_n = 0` at the edge): all slots empty with data 0, and `rr_ptr = 0`.
  - Outputs that cycle onward: `cdb_select_flag = 0`, selects, tags, values, `cdb_mispredict` and `cdb_pc` all 0.
  - `fu_ready` is all 1.
- Reset mid-stall discards buffered results.
- **Latency:** a result accepted at edge N appears on the bus in cycle N+1 if it wins. Worst case is FU_NUM cycles of wait under full contention.
- **Throughput:** one broadcast per cycle. Each FU can sustain one result per cycle while it keeps winning.
- **Simultaneous events:** reset beats squash. Squash beats accept and refill. Grant plus accept on the same slot leaves it full with the new data.
- `squash` and `reset_n` take effect only at the clock edge. There are no asynchronous paths.

## Configuration
- **`CDB_BTU_PRIORITY_EN` defined:** a full BTU slot always wins, regardless of `rr_ptr`. `rr_ptr` does not advance on a BTU grant, so the other FUs keep their round-robin order.
- **Not defined:** the BTU competes in plain round-robin like every other slot.

## Test plan
- **Reset:** hold `reset_n = 0` for 2 cycles with all `fu_valid = 1` → `fu_ready` stays all 1, no slot loads, `cdb_select_flag = 0`, all outputs 0.
- **Single request:** slot 2 accepts value 0xDEADBEEF with tag 5 at edge N → in cycle N+1 the bus shows select=2, tag=5, `cdb_values[2]` = 0xDEADBEEF. In cycle N+2 (no new input), `cdb_select_flag = 0`.
- **Full contention:** all 4 FUs valid every cycle with `rr_ptr = 0` → grants 0, 1, 2, 3, 0 on consecutive cycles. A non-granted `fu_ready` stays 0 while its slot is full, and no tag is lost or repeated.
- **Squash:** slots 1 and 3 full, `squash = 1` with `fu_valid[0] = 1` → next cycle all slots are empty, `cdb_select_flag = 0`, and slot 0 did not load.
- **BTU result:** BTU slot loaded with mispredict=1, pc=0x1000 → on its grant cycle `cdb_mispredict = 1` and `cdb_pc = 0x1000`. On a non-BTU grant cycle both read 0.
- **Priority macro:** with `CDB_BTU_PRIORITY_EN`, BTU and slot 0 both full and `rr_ptr = 0` → BTU is granted first, then slot 0, and `rr_ptr` stays 0 after the BTU grant. Without the macro → slot 0 is granted first.
